// File: rtl/chu_mmio_arbiter.sv
// Two-requester round-robin arbiter onto a single FPro MMIO bus.
// Each transaction takes IDLE -> ISSUE (bus strobe) -> RESP (ack): three cycles.
module chu_mmio_arbiter #(
   parameter int ADDR_W = 21,
   parameter int DATA_W = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              m0_req,
   input  logic              m0_wr,
   input  logic [ADDR_W-1:0] m0_addr,
   input  logic [DATA_W-1:0] m0_wdata,
   output logic              m0_ack,
   output logic [DATA_W-1:0] m0_rdata,
   input  logic              m1_req,
   input  logic              m1_wr,
   input  logic [ADDR_W-1:0] m1_addr,
   input  logic [DATA_W-1:0] m1_wdata,
   output logic              m1_ack,
   output logic [DATA_W-1:0] m1_rdata,
   output logic              mmio_cs,
   output logic              mmio_wr,
   output logic              mmio_rd,
   output logic [ADDR_W-1:0] mmio_addr,
   output logic [DATA_W-1:0] mmio_wdata,
   input  logic [DATA_W-1:0] mmio_rdata,
   output logic              busy
);

   typedef enum logic [1:0] {IDLE, ISSUE, RESP} state_t;

   state_t              state_q, state_d;
   logic                last_grant_q, last_grant_d;
   logic                grant_q, grant_d;
   logic                reg_wr_q, reg_wr_d;
   logic [ADDR_W-1:0]   addr_q, addr_d;
   logic [DATA_W-1:0]   wdata_q, wdata_d;
   logic [DATA_W-1:0]   rdata0_q, rdata0_d;
   logic [DATA_W-1:0]   rdata1_q, rdata1_d;
   logic                win;

   always_comb begin
      state_d      = state_q;
      last_grant_d = last_grant_q;
      grant_d      = grant_q;
      reg_wr_d     = reg_wr_q;
      addr_d       = addr_q;
      wdata_d      = wdata_q;
      rdata0_d     = rdata0_q;
      rdata1_d     = rdata1_q;
      // On a tie the requester that did not win last time goes first.
      win = (m0_req && m1_req) ? ~last_grant_q : m1_req;
      case (state_q)
         IDLE: begin
            if (m0_req || m1_req) begin
               grant_d  = win;
               reg_wr_d = win ? m1_wr    : m0_wr;
               addr_d   = win ? m1_addr  : m0_addr;
               wdata_d  = win ? m1_wdata : m0_wdata;
               state_d  = ISSUE;
            end
         end
         ISSUE: begin
            if (!reg_wr_q) begin
               if (grant_q) rdata1_d = mmio_rdata;
               else         rdata0_d = mmio_rdata;
            end
            state_d = RESP;
         end
         RESP: begin
            last_grant_d = grant_q;
            state_d      = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= IDLE;
         last_grant_q <= 1'b1;
         grant_q      <= 1'b0;
         reg_wr_q     <= 1'b0;
         addr_q       <= '0;
         wdata_q      <= '0;
         rdata0_q     <= '0;
         rdata1_q     <= '0;
      end else begin
         state_q      <= state_d;
         last_grant_q <= last_grant_d;
         grant_q      <= grant_d;
         reg_wr_q     <= reg_wr_d;
         addr_q       <= addr_d;
         wdata_q      <= wdata_d;
         rdata0_q     <= rdata0_d;
         rdata1_q     <= rdata1_d;
      end
   end

   assign mmio_cs    = (state_q == ISSUE);
   assign mmio_wr    = mmio_cs &  reg_wr_q;
   assign mmio_rd    = mmio_cs & ~reg_wr_q;
   assign mmio_addr  = addr_q;
   assign mmio_wdata = wdata_q;
   assign m0_ack     = (state_q == RESP) & ~grant_q;
   assign m1_ack     = (state_q == RESP) &  grant_q;
   assign m0_rdata   = rdata0_q;
   assign m1_rdata   = rdata1_q;
   assign busy       = (state_q != IDLE);

endmodule

// File: tb/tb_chu_mmio_arbiter.sv
// Scoreboard bench: directed stimulus pushes expected bus strobes and acks
// (with their exact cycle); a negedge monitor pops and compares them.
module tb_chu_mmio_arbiter;

   localparam int AW = 21;
   localparam int DW = 32;

   logic          clk = 1'b0;
   logic          rst;
   logic          m0_req, m0_wr, m1_req, m1_wr;
   logic [AW-1:0] m0_addr, m1_addr, mmio_addr;
   logic [DW-1:0] m0_wdata, m1_wdata, m0_rdata, m1_rdata, mmio_wdata, mmio_rdata;
   logic          m0_ack, m1_ack, mmio_cs, mmio_wr, mmio_rd, busy;

   chu_mmio_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
      .clk(clk), .rst(rst),
      .m0_req(m0_req), .m0_wr(m0_wr), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
      .m0_ack(m0_ack), .m0_rdata(m0_rdata),
      .m1_req(m1_req), .m1_wr(m1_wr), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
      .m1_ack(m1_ack), .m1_rdata(m1_rdata),
      .mmio_cs(mmio_cs), .mmio_wr(mmio_wr), .mmio_rd(mmio_rd),
      .mmio_addr(mmio_addr), .mmio_wdata(mmio_wdata), .mmio_rdata(mmio_rdata),
      .busy(busy)
   );

   always #5 clk = ~clk;

   typedef struct {
      int            cyc;
      logic          wr;
      logic [AW-1:0] addr;
      logic [DW-1:0] wdata;
   } bus_t;

   typedef struct {
      int            cyc;
      logic          who;
      logic [DW-1:0] r0;
      logic [DW-1:0] r1;
   } ack_t;

   bus_t bus_q[$];
   ack_t ack_q[$];
   int   cyc = 0;
   int   checks = 0;
   int   failures = 0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s cyc=%0d actual=%0h expected=%0h", name, cyc, act, exp);
      end
   endtask

   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   // Monitor: every strobe and every ack must match the head of its queue.
   always @(negedge clk) begin
      bus_t b;
      ack_t a;
      if (mmio_wr === 1'b1 || mmio_rd === 1'b1)
         chk("wr_rd_excl", {62'd0, mmio_wr, mmio_rd} == 64'd3, 64'd0);
      if (mmio_cs === 1'b1) begin
         if (bus_q.size() == 0) chk("bus_unexpected", 64'd1, 64'd0);
         else begin
            b = bus_q.pop_front();
            chk("bus_cycle", 64'(cyc), 64'(b.cyc));
            chk("bus_wr", 64'(mmio_wr), 64'(b.wr));
            chk("bus_rd", 64'(mmio_rd), 64'(!b.wr));
            chk("bus_addr", 64'(mmio_addr), 64'(b.addr));
            chk("bus_wdata", 64'(mmio_wdata), 64'(b.wdata));
            chk("bus_busy", 64'(busy), 64'd1);
         end
      end
      if (m0_ack === 1'b1 || m1_ack === 1'b1) begin
         if (ack_q.size() == 0) chk("ack_unexpected", {m1_ack, m0_ack}, 64'd0);
         else begin
            a = ack_q.pop_front();
            chk("ack_cycle", 64'(cyc), 64'(a.cyc));
            chk("ack_who", {62'd0, m1_ack, m0_ack}, a.who ? 64'd2 : 64'd1);
            chk("ack_m0_rdata", 64'(m0_rdata), 64'(a.r0));
            chk("ack_m1_rdata", 64'(m1_rdata), 64'(a.r1));
         end
      end
   end

   int n;

   initial begin
      rst = 1'b1;
      {m0_req, m0_wr, m1_req, m1_wr} = '0;
      m0_addr = '0; m1_addr = '0; m0_wdata = '0; m1_wdata = '0; mmio_rdata = '0;
      step(2);
      rst = 1'b0;

      // reset state
      @(negedge clk);
      chk("rst_cs", mmio_cs, 0);     chk("rst_wr", mmio_wr, 0);
      chk("rst_rd", mmio_rd, 0);     chk("rst_busy", busy, 0);
      chk("rst_addr", mmio_addr, 0); chk("rst_wdata", mmio_wdata, 0);
      chk("rst_ack0", m0_ack, 0);    chk("rst_ack1", m1_ack, 0);
      chk("rst_r0", m0_rdata, 0);    chk("rst_r1", m1_rdata, 0);
      step(1);

      // single m0 write
      n = cyc;
      m0_req = 1; m0_wr = 1; m0_addr = 21'h00044; m0_wdata = 32'hDEADBEEF;
      bus_q.push_back('{n+1, 1'b1, 21'h00044, 32'hDEADBEEF});
      ack_q.push_back('{n+2, 1'b0, 32'h0, 32'h0});
      step(3); m0_req = 0; step(1);

      // single m1 read
      n = cyc;
      mmio_rdata = 32'h12345678;
      m1_req = 1; m1_wr = 0; m1_addr = 21'h00062; m1_wdata = 32'h0;
      bus_q.push_back('{n+1, 1'b0, 21'h00062, 32'h0});
      ack_q.push_back('{n+2, 1'b1, 32'h0, 32'h12345678});
      step(3); m1_req = 0; step(1);

      // tie after reset: m0, m1, m0, m1, acks 3 cycles apart; reset also clears m1_rdata
      rst = 1; step(1); rst = 0;
      n = cyc;
      m0_req = 1; m0_wr = 1; m0_addr = 21'h10; m0_wdata = 32'hA0;
      m1_req = 1; m1_wr = 1; m1_addr = 21'h20; m1_wdata = 32'hB0;
      for (int k = 0; k < 4; k++) begin
         bus_q.push_back('{n+1+3*k, 1'b1, (k%2) ? 21'h20 : 21'h10, (k%2) ? 32'hB0 : 32'hA0});
         ack_q.push_back('{n+2+3*k, 1'(k%2), 32'h0, 32'h0});
      end
      step(12); m0_req = 0; m1_req = 0; step(1);

      // inputs change while in flight
      n = cyc;
      mmio_rdata = 32'hCAFE0001;
      m0_req = 1; m0_wr = 0; m0_addr = 21'h100; m0_wdata = 32'h77;
      bus_q.push_back('{n+1, 1'b0, 21'h100, 32'h77});
      ack_q.push_back('{n+2, 1'b0, 32'hCAFE0001, 32'h0});
      step(1);
      m0_addr = 21'h200; m0_wdata = 32'h88; m0_wr = 1;
      step(2); m0_req = 0; step(1);

      // reset during ISSUE of an m0 read, req held
      n = cyc;
      mmio_rdata = 32'h55AA55AA;
      m0_req = 1; m0_wr = 0; m0_addr = 21'h300; m0_wdata = 32'h99;
      bus_q.push_back('{n+1, 1'b0, 21'h300, 32'h99});
      step(1); rst = 1; step(2); rst = 0;
      @(negedge clk);
      chk("midrst_busy", busy, 0);
      chk("midrst_r0", m0_rdata, 0);
      bus_q.push_back('{n+4, 1'b0, 21'h300, 32'h99});
      ack_q.push_back('{n+5, 1'b0, 32'h55AA55AA, 32'h0});
      step(3); m0_req = 0; step(1);

      // idle bus for 10 cycles
      for (int k = 0; k < 10; k++) begin
         @(negedge clk);
         chk("idle_cs", mmio_cs, 0); chk("idle_wr", mmio_wr, 0);
         chk("idle_rd", mmio_rd, 0); chk("idle_busy", busy, 0);
      end

      step(3);
      chk("bus_q_drained", 64'(bus_q.size()), 64'd0);
      chk("ack_q_drained", 64'(ack_q.size()), 64'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/chu_mmio_arbiter.md
CHU_MMIO_ARBITER -- requirements
Module: chu_mmio_arbiter

Interface
REQ-001 The block SHALL have parameter ADDR_W, default 21, meaning the FPro MMIO address width.
REQ-002 The block SHALL have parameter DATA_W, default 32, meaning the FPro MMIO data width.
REQ-003 The block SHALL have one clock and one reset; reset is synchronous and active-high.
REQ-004 clk  input  1  sole clock; all state changes on its rising edge.
REQ-005 rst  input  1  synchronous, active-high reset.
REQ-006 m0_req  input  1  requester 0 transaction request, held high until m0_ack.
REQ-007 m0_wr  input  1  requester 0 type: 1 is write, 0 is read.
REQ-008 m0_addr  input  ADDR_W  requester 0 MMIO address.
REQ-009 m0_wdata  input  DATA_W  requester 0 write data.
REQ-010 m0_ack  output  1  one-cycle completion pulse to requester 0.
REQ-011 m0_rdata  output  DATA_W  last read data returned to requester 0.
REQ-012 m1_req, m1_wr, m1_addr, m1_wdata, m1_ack, m1_rdata SHALL mirror REQ-006..REQ-011 for requester 1.
REQ-013 mmio_cs  output  1  FPro bus chip select.
REQ-014 mmio_wr  output  1  FPro bus write strobe.
REQ-015 mmio_rd  output  1  FPro bus read strobe.
REQ-016 mmio_addr  output  ADDR_W  FPro bus address.
REQ-017 mmio_wdata  output  DATA_W  FPro bus write data.
REQ-018 mmio_rdata  input  DATA_W  FPro bus read data, valid combinationally while cs/rd/addr are driven.
REQ-019 busy  output  1  high whenever the FSM is not in IDLE.

Function
REQ-020 The FSM SHALL have states IDLE, ISSUE and RESP.
REQ-021 IDLE: with no req asserted, the FSM SHALL remain in IDLE.
REQ-022 IDLE: with any req asserted, the FSM SHALL select a winner, register its wr/addr/wdata plus a grant index, and go to ISSUE.
REQ-023 Arbitration SHALL be round-robin: when only one req is high, that requester wins; when both are high, the requester not equal to last_grant wins.
REQ-024 ISSUE: the block SHALL drive mmio_cs=1 for exactly one cycle, with mmio_wr=reg_wr and mmio_rd=~reg_wr, from the registered address and data; it SHALL then go to RESP.
REQ-025 ISSUE on a read: the block SHALL capture mmio_rdata at the end of the cycle into the granted requester's rdata register.
REQ-026 RESP: the block SHALL assert the granted requester's ack for one cycle, set last_grant to the grant index, and return to IDLE.
REQ-027 Latency: req sampled in IDLE at cycle N SHALL give the bus strobe in cycle N+1 and ack in cycle N+2; maximum throughput is one transaction per 3 cycles.
REQ-028 A requester SHALL, on the edge ending its ack cycle, either deassert req or present a new transaction; the arbiter samples the new value in the following IDLE cycle.
REQ-029 Outside ISSUE, mmio_cs, mmio_wr and mmio_rd SHALL be 0; mmio_addr and mmio_wdata SHALL hold their last registered values.
REQ-030 mX_rdata SHALL change only on a read granted to requester X; writes and the other requester's reads SHALL leave it unchanged.
REQ-031 Changes on req, addr, wdata or wr during ISSUE or RESP SHALL have no effect on the transaction in flight.
REQ-032 m0_ack and m1_ack SHALL never be high in the same cycle, and mmio_wr and mmio_rd SHALL never be high together.
REQ-033 A requester SHALL not be starved: while the other requester is continuously requesting, a pending requester is granted within one transaction.

Reset
REQ-034 On rst=1 at a clock edge, the block SHALL set: FSM=IDLE; last_grant=1, so requester 0 wins the first tie; all ack=0; mmio_cs/wr/rd=0; mmio_addr=0; mmio_wdata=0; m0_rdata=0; m1_rdata=0; busy=0.
REQ-035 Reset in ISSUE or RESP SHALL abort the transaction with no ack; a req still held after reset is re-arbitrated from IDLE.
REQ-036 rst SHALL override all other inputs in the cycle it is sampled.

Verification
REQ-037 Single write: m0 write to addr 0x00044 with data 0xDEADBEEF -> mmio_cs=1 and mmio_wr=1 one cycle later with those values; m0_ack the cycle after; m0_rdata unchanged at 0.
REQ-038 Single read: m1 read of 0x00062 while the bus returns 0x12345678 -> mmio_rd=1 for one cycle, then m1_ack=1 and m1_rdata=0x12345678; m0_rdata stays 0.
REQ-039 Tie after reset: m0 and m1 both request continuously -> grants m0, m1, m0, m1 with acks spaced 3 cycles apart.
REQ-040 Input changes mid-flight: m0 changes addr during ISSUE -> the bus carries the addr registered in IDLE.
REQ-041 Reset mid-flight: rst asserted during ISSUE of an m0 read, req held -> no ack while rst is high; after release the read is re-issued, then m0_ack.
REQ-042 Idle bus: no req for 10 cycles -> mmio_cs, mmio_wr, mmio_rd and busy stay 0 throughout.
